// File: rtl/sha_round_if.sv
// Handshake and data bundle between the SHA-256 round controller and its host/sha_unit side.
interface sha_round_if;
  logic         start;
  logic [255:0] H1;
  logic [5:0]   round;
  logic [31:0]  Kt;
  logic         busy;
  logic         done;
  logic [255:0] H_out;

  modport master (output start, output H1,
                  input  round, input Kt, input busy, input done, input H_out);
  modport slave  (input  start, input H1,
                  output round, output Kt, output busy, output done, output H_out);
endinterface

// File: rtl/sha_round_controller.sv
// SHA-256 round sequencer: walks round 0..63 with matching K constant, then captures H1.
//   state   | meaning
//   IDLE    | waiting for start, round/Kt parked at 0/K[0]
//   RUN     | one round per cycle, round 0..63
//   CAPTURE | latch H1 into H_out, done follows in the next IDLE cycle
module sha_round_controller (
  input  logic      clk,
  input  logic      reset,
  sha_round_if.slave bus
);

  typedef enum logic [1:0] {IDLE, RUN, CAPTURE} state_t;

  localparam logic [31:0] K [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
    32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
    32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
    32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
    32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
    32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
    32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
    32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
    32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  state_t       state_q, state_d;
  logic [5:0]   round_q, round_d;
  logic [31:0]  kt_q;
  logic         done_q;
  logic [255:0] h_out_q;

  always_comb begin
    state_d = state_q;
    round_d = 6'd0;
    case (state_q)
      IDLE:    if (bus.start) state_d = RUN;
      RUN: begin
        round_d = round_q + 6'd1;   // wraps 63 -> 0 on the way into CAPTURE
        if (round_q == 6'd63) state_d = CAPTURE;
      end
      CAPTURE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Kt is looked up from the next round so it moves on the same edge as round.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      round_q <= 6'd0;
      kt_q    <= 32'h428a2f98;
      done_q  <= 1'b0;
      h_out_q <= '0;
    end else begin
      state_q <= state_d;
      round_q <= round_d;
      kt_q    <= K[round_d];
      done_q  <= (state_q == CAPTURE);
      if (state_q == CAPTURE) h_out_q <= bus.H1;
    end
  end

  assign bus.round = round_q;
  assign bus.Kt    = kt_q;
  assign bus.busy  = (state_q != IDLE);
  assign bus.done  = done_q;
  assign bus.H_out = h_out_q;

endmodule

// File: tb/tb_sha_round_controller.sv
// Directed bench for sha_round_controller: K/round sequence, capture timing, start/reset corner cases.
module tb_sha_round_controller;

  logic clk = 1'b0;
  logic reset = 1'b1;
  sha_round_if bus();

  sha_round_controller dut (.clk(clk), .reset(reset), .bus(bus));

  always #5 clk = ~clk;

  localparam logic [255:0] GOLDEN =
    256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
  localparam logic [255:0] JUNK = {8{32'hdeadbeef}};

  localparam logic [31:0] KREF [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
    32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
    32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
    32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
    32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
    32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
    32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
    32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
    32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  // {cycle offset after start, expected round, Kt, busy, done}
  typedef struct {
    int          off;
    logic [5:0]  round;
    logic [31:0] kt;
    logic        busy;
    logic        done;
  } vec_t;

  vec_t         vecs [11];
  int           n_checks = 0;
  int           n_fail   = 0;
  logic [255:0] exp_hout;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_round"}, 256'(bus.round), 256'(6'd0));
    chk({tag, "_kt"},    256'(bus.Kt),    256'(32'h428a2f98));
    chk({tag, "_busy"},  256'(bus.busy),  256'(1'b0));
    chk({tag, "_done"},  256'(bus.done),  256'(1'b0));
    chk({tag, "_hout"},  bus.H_out,       exp_hout);
  endtask

  // Caller has already put start=1 in the current cycle t; this walks t+1..t+66.
  task automatic run_body(input bit hold, input bit use_table);
    logic [5:0] er;
    logic       eb, ed;
    for (int off = 1; off <= 66; off++) begin
      step();
      bus.start = hold && ((off >= 11 && off <= 41) || off == 65);
      bus.H1    = (off == 65) ? GOLDEN : JUNK;
      er = (off <= 64) ? 6'(off - 1) : 6'd0;
      eb = (off <= 65);
      ed = (off == 66);
      if (off == 66) exp_hout = GOLDEN;
      chk($sformatf("round@%0d", off), 256'(bus.round), 256'(er));
      chk($sformatf("kt@%0d", off),    256'(bus.Kt),    256'(KREF[er]));
      chk($sformatf("busy@%0d", off),  256'(bus.busy),  256'(eb));
      chk($sformatf("done@%0d", off),  256'(bus.done),  256'(ed));
      chk($sformatf("hout@%0d", off),  bus.H_out,       exp_hout);
      if (use_table) begin
        for (int v = 0; v < 11; v++) begin
          if (vecs[v].off == off) begin
            chk($sformatf("vec%0d_round", v), 256'(bus.round), 256'(vecs[v].round));
            chk($sformatf("vec%0d_kt", v),    256'(bus.Kt),    256'(vecs[v].kt));
            chk($sformatf("vec%0d_busy", v),  256'(bus.busy),  256'(vecs[v].busy));
            chk($sformatf("vec%0d_done", v),  256'(bus.done),  256'(vecs[v].done));
          end
        end
      end
    end
    bus.start = 1'b0;
  endtask

  initial begin
    int dcount, bcount;
    vecs[0]  = '{1,  6'd0,  32'h428a2f98, 1'b1, 1'b0};
    vecs[1]  = '{2,  6'd1,  32'h71374491, 1'b1, 1'b0};
    vecs[2]  = '{3,  6'd2,  32'hb5c0fbcf, 1'b1, 1'b0};
    vecs[3]  = '{9,  6'd8,  32'hd807aa98, 1'b1, 1'b0};
    vecs[4]  = '{17, 6'd16, 32'he49b69c1, 1'b1, 1'b0};
    vecs[5]  = '{33, 6'd32, 32'h27b70a85, 1'b1, 1'b0};
    vecs[6]  = '{49, 6'd48, 32'h19a4c116, 1'b1, 1'b0};
    vecs[7]  = '{64, 6'd63, 32'hc67178f2, 1'b1, 1'b0};
    vecs[8]  = '{65, 6'd0,  32'h428a2f98, 1'b1, 1'b0};
    vecs[9]  = '{66, 6'd0,  32'h428a2f98, 1'b0, 1'b1};
    vecs[10] = '{67, 6'd0,  32'h428a2f98, 1'b0, 1'b0};

    bus.start = 1'b0;
    bus.H1    = JUNK;
    exp_hout  = '0;
    reset     = 1'b1;
    step();
    step();
    reset = 1'b0;
    chk_idle("reset");
    step();
    chk_idle("idle_hold");

    // single run, table-checked
    bus.start = 1'b1;
    run_body(1'b0, 1'b1);
    step();
    chk_idle("after_run1");

    // start held during RUN and pulsed in CAPTURE: ignored
    bus.start = 1'b1;
    run_body(1'b1, 1'b0);
    step();
    chk_idle("after_hold");

    // back-to-back: second start lands in the done cycle
    bus.start = 1'b1;
    run_body(1'b0, 1'b0);
    bus.start = 1'b1;
    run_body(1'b0, 1'b0);
    step();
    chk_idle("after_b2b");

    // reset at round 30 aborts the run
    bus.start = 1'b1;
    repeat (31) begin
      step();
      bus.start = 1'b0;
    end
    chk("abort_round30", 256'(bus.round), 256'(6'd30));
    reset = 1'b1;
    step();
    reset = 1'b0;
    exp_hout = '0;
    chk_idle("abort");
    dcount = 0;
    bcount = 0;
    for (int i = 0; i < 100; i++) begin
      step();
      if (bus.done) dcount++;
      if (bus.busy) bcount++;
    end
    chk("abort_no_done", 256'(dcount), 256'(0));
    chk("abort_no_busy", 256'(bcount), 256'(0));
    chk("abort_hout", bus.H_out, 256'(0));

    // reset beats start in the same cycle
    bus.start = 1'b1;
    reset     = 1'b1;
    step();
    bus.start = 1'b0;
    reset     = 1'b0;
    chk_idle("rst_start");
    step();
    chk_idle("rst_start_next");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
